// File: rtl/mem_arbiter_ctrl_pkg.sv
// Shared definitions for the fetch/data memory arbiter: FSM state encodings,
// grantee identifiers and a counter sizing helper.
package mem_arbiter_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_BUSY_IF = 2'b01,
      ST_BUSY_D  = 2'b10,
      ST_HALTED  = 2'b11
   } state_e;

   typedef enum logic {
      GRANT_IF = 1'b0,
      GRANT_D  = 1'b1
   } grant_e;

   // Down-counter width able to hold MEM_LAT-1 (at least one bit).
   function automatic int cnt_width(input int lat);
      return (lat > 1) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_ctrl_lat_counter.sv
// Loadable access-latency down-counter: loads MEM_LAT-1 on grant, counts
// down while the access is in flight and flags zero on the final cycle.
module mem_arbiter_ctrl_lat_counter #(
   parameter int MEM_LAT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);
   import mem_arbiter_ctrl_pkg::*;

   localparam int            CW       = cnt_width(MEM_LAT);
   localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LAT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Next count: load wins over decrement, and the count saturates at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (dec_i && (cnt_q != {CW{1'b0}})) begin
         cnt_d = cnt_q - CW'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= {CW{1'b0}};
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Shared multi-cycle memory sequencer: arbitrates instruction fetch against
// data access with alternating priority, and shuts down on halt or misalignment.
module mem_arbiter_ctrl #(
   parameter int MEM_LAT = 4,
   parameter int AW      = 16,
   parameter int DW      = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic [DW-1:0] if_rdata,
   output logic          if_done,
   input  logic          d_req,
   input  logic          d_wr,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_done,
   input  logic          halt,
   output logic          mem_en,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          stall,
   output logic          halted,
   output logic          err
);
   import mem_arbiter_ctrl_pkg::*;

   state_e        state_q, state_d;
   grant_e        last_grant_q, last_grant_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          wr_q, wr_d;
   logic [DW-1:0] if_rdata_q, if_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          if_done_q, if_done_d;
   logic          d_done_q, d_done_d;
   logic          err_q, err_d;
   logic          load_s, dec_s, cnt_zero_s;
   logic          elig_if_s, elig_d_s, pick_d_s, busy_s;
   logic [AW-1:0] sel_addr_s;

   // A requester whose done is pulsing this cycle is not re-granted.
   assign elig_if_s  = if_req & ~if_done_q;
   assign elig_d_s   = d_req & ~d_done_q;
   assign pick_d_s   = elig_d_s & (~elig_if_s | (last_grant_q == GRANT_IF));
   assign sel_addr_s = pick_d_s ? d_addr : if_addr;
   assign busy_s     = (state_q == ST_BUSY_IF) || (state_q == ST_BUSY_D);

   mem_arbiter_ctrl_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat_counter (
      .clk    (clk),
      .rst    (rst),
      .load_i (load_s),
      .dec_i  (dec_s),
      .zero_o (cnt_zero_s)
   );

   // Arbiter FSM: grant, latch request, run access, publish completion.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wr_d         = wr_q;
      if_rdata_d   = if_rdata_q;
      d_rdata_d    = d_rdata_q;
      if_done_d    = 1'b0;
      d_done_d     = 1'b0;
      err_d        = err_q;
      load_s       = 1'b0;
      dec_s        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (halt) begin
               state_d = ST_HALTED;
            end else if (elig_if_s || elig_d_s) begin
               if (sel_addr_s[0]) begin
                  err_d   = 1'b1;
                  state_d = ST_HALTED;
               end else begin
                  load_s       = 1'b1;
                  last_grant_d = pick_d_s ? GRANT_D : GRANT_IF;
                  addr_d       = sel_addr_s;
                  wdata_d      = pick_d_s ? d_wdata : {DW{1'b0}};
                  wr_d         = pick_d_s & d_wr;
                  state_d      = pick_d_s ? ST_BUSY_D : ST_BUSY_IF;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY_IF, ST_BUSY_D: begin
            if (cnt_zero_s) begin
               if (state_q == ST_BUSY_IF) begin
                  if_rdata_d = mem_rdata;
                  if_done_d  = 1'b1;
               end else begin
                  d_rdata_d = wr_q ? {DW{1'b0}} : mem_rdata;
                  d_done_d  = 1'b1;
               end
               state_d = halt ? ST_HALTED : ST_IDLE;
            end else begin
               dec_s = 1'b1;
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, request latches and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GRANT_IF;
         addr_q       <= {AW{1'b0}};
         wdata_q      <= {DW{1'b0}};
         wr_q         <= 1'b0;
         if_rdata_q   <= {DW{1'b0}};
         d_rdata_q    <= {DW{1'b0}};
         if_done_q    <= 1'b0;
         d_done_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wr_q         <= wr_d;
         if_rdata_q   <= if_rdata_d;
         d_rdata_q    <= d_rdata_d;
         if_done_q    <= if_done_d;
         d_done_q     <= d_done_d;
         err_q        <= err_d;
      end
   end

   assign mem_en    = busy_s;
   assign mem_wr    = (state_q == ST_BUSY_D) & wr_q;
   assign mem_addr  = busy_s ? addr_q : {AW{1'b0}};
   assign mem_wdata = (state_q == ST_BUSY_D) ? wdata_q : {DW{1'b0}};
   assign if_rdata  = if_rdata_q;
   assign if_done   = if_done_q;
   assign d_rdata   = d_rdata_q;
   assign d_done    = d_done_q;
   assign halted    = (state_q == ST_HALTED);
   assign err       = err_q;
   assign stall     = (if_req & ~if_done_q) | (d_req & ~d_done_q) | halted;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// Directed self-checking bench for mem_arbiter_ctrl (MEM_LAT=4 and MEM_LAT=1 builds).
module tb_mem_arbiter_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req, d_req, d_wr, halt;
   logic [15:0] if_addr, d_addr, d_wdata, mem_rdata;
   logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
   logic        if_done, d_done, mem_en, mem_wr, stall, halted, err;

   logic        if_req1, d_req1, d_wr1, halt1;
   logic [15:0] if_addr1, d_addr1, d_wdata1, mem_rdata1;
   logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
   logic        if_done1, d_done1, mem_en1, mem_wr1, stall1, halted1, err1;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_arbiter_ctrl #(.MEM_LAT(4), .AW(16), .DW(16)) u_dut (
      .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_done(if_done), .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_done(d_done), .halt(halt), .mem_en(mem_en), .mem_wr(mem_wr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall),
      .halted(halted), .err(err)
   );

   mem_arbiter_ctrl #(.MEM_LAT(1), .AW(16), .DW(16)) u_dut1 (
      .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr1), .if_rdata(if_rdata1),
      .if_done(if_done1), .d_req(d_req1), .d_wr(d_wr1), .d_addr(d_addr1), .d_wdata(d_wdata1),
      .d_rdata(d_rdata1), .d_done(d_done1), .halt(halt1), .mem_en(mem_en1), .mem_wr(mem_wr1),
      .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .stall(stall1),
      .halted(halted1), .err(err1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      if_req = 1'b0; d_req = 1'b0; d_wr = 1'b0; halt = 1'b0;
      if_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000; mem_rdata = 16'h0000;
      if_req1 = 1'b0; d_req1 = 1'b0; d_wr1 = 1'b0; halt1 = 1'b0;
      if_addr1 = 16'h0000; d_addr1 = 16'h0000; d_wdata1 = 16'h0000; mem_rdata1 = 16'h0000;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({mem_en, mem_wr, if_done, d_done, stall, halted, err} !== 7'b0000000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=%b",
                  {mem_en, mem_wr, if_done, d_done, stall, halted, err}, 7'b0000000);
      end
      checks++;
      if ({if_rdata, d_rdata, mem_addr, mem_wdata} !== 64'h0) begin
         failures++;
         $display("FAIL reset_data got=%h exp=%h", {if_rdata, d_rdata, mem_addr, mem_wdata}, 64'h0);
      end
   endtask

   task automatic test_fetch();
      do_reset();
      if_addr = 16'h0010; if_req = 1'b1; mem_rdata = 16'hA5A5;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL fetch_stall got=%b exp=%b", stall, 1'b1);
      end
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if ({mem_en, mem_wr, if_done, mem_addr} !== {3'b100, 16'h0010}) begin
            failures++;
            $display("FAIL fetch_busy k=%0d got=%b%b%b/%h exp=100/0010", k, mem_en, mem_wr, if_done, mem_addr);
         end
      end
      tick();
      checks++;
      if ({mem_en, if_done, stall, if_rdata} !== {3'b010, 16'hA5A5}) begin
         failures++;
         $display("FAIL fetch_done got=%b%b%b/%h exp=010/a5a5", mem_en, if_done, stall, if_rdata);
      end
      if_req = 1'b0;
      mem_rdata = 16'h0000;
      tick();
      checks++;
      if ({if_done, mem_en, if_rdata} !== {2'b00, 16'hA5A5}) begin
         failures++;
         $display("FAIL fetch_hold got=%b%b/%h exp=00/a5a5", if_done, mem_en, if_rdata);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      if_req = 1'b1; if_addr = 16'h0010;
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0200; mem_rdata = 16'h5A5A;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if ({mem_en, mem_addr} !== {1'b1, 16'h0200}) begin
            failures++;
            $display("FAIL b2b_data_busy k=%0d got=%b/%h exp=1/0200", k, mem_en, mem_addr);
         end
      end
      tick();
      checks++;
      if ({d_done, if_done, mem_en, stall, d_rdata} !== {4'b1001, 16'h5A5A}) begin
         failures++;
         $display("FAIL b2b_d_done got=%b%b%b%b/%h exp=1001/5a5a", d_done, if_done, mem_en, stall, d_rdata);
      end
      d_req = 1'b0;
      mem_rdata = 16'h1111;
      for (int k = 6; k <= 9; k++) begin
         tick();
         checks++;
         if ({mem_en, mem_addr, d_done} !== {1'b1, 16'h0010, 1'b0}) begin
            failures++;
            $display("FAIL b2b_if_busy k=%0d got=%b/%h/%b exp=1/0010/0", k, mem_en, mem_addr, d_done);
         end
      end
      tick();
      checks++;
      if ({if_done, d_done, if_rdata, d_rdata} !== {2'b10, 16'h1111, 16'h5A5A}) begin
         failures++;
         $display("FAIL b2b_if_done got=%b%b/%h/%h exp=10/1111/5a5a", if_done, d_done, if_rdata, d_rdata);
      end
      if_req = 1'b0;
   endtask

   task automatic test_store();
      do_reset();
      d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234; mem_rdata = 16'hBEEF;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if ({mem_en, mem_wr, d_done, mem_addr, mem_wdata} !== {3'b110, 16'h0040, 16'h1234}) begin
            failures++;
            $display("FAIL store_busy k=%0d got=%b%b%b/%h/%h exp=110/0040/1234",
                     k, mem_en, mem_wr, d_done, mem_addr, mem_wdata);
         end
      end
      tick();
      checks++;
      if ({d_done, mem_en, mem_wr, d_rdata} !== {3'b100, 16'h0000}) begin
         failures++;
         $display("FAIL store_done got=%b%b%b/%h exp=100/0000", d_done, mem_en, mem_wr, d_rdata);
      end
      d_req = 1'b0;
      tick();
      checks++;
      if ({d_done, mem_en} !== 2'b00) begin
         failures++;
         $display("FAIL store_once got=%b%b exp=00", d_done, mem_en);
      end
   endtask

   task automatic test_halt();
      do_reset();
      if_req = 1'b1; if_addr = 16'h0020; mem_rdata = 16'hC3C3;
      tick();
      tick();
      halt = 1'b1;
      tick();
      tick();
      checks++;
      if ({mem_en, if_done, halted} !== 3'b100) begin
         failures++;
         $display("FAIL halt_busy got=%b%b%b exp=100", mem_en, if_done, halted);
      end
      tick();
      checks++;
      if ({if_done, halted, stall, mem_en, if_rdata} !== {4'b1110, 16'hC3C3}) begin
         failures++;
         $display("FAIL halt_done got=%b%b%b%b/%h exp=1110/c3c3", if_done, halted, stall, mem_en, if_rdata);
      end
      if_req = 1'b0; halt = 1'b0; d_req = 1'b1; d_addr = 16'h0100;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if ({halted, stall, mem_en, if_done, d_done} !== 5'b11000) begin
            failures++;
            $display("FAIL halt_stuck k=%0d got=%b exp=11000", k, {halted, stall, mem_en, if_done, d_done});
         end
      end
   endtask

   task automatic test_misalign();
      do_reset();
      d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0003;
      for (int k = 1; k <= 4; k++) begin
         tick();
         checks++;
         if ({mem_en, d_done, err, halted} !== 4'b0011) begin
            failures++;
            $display("FAIL misalign k=%0d got=%b exp=0011", k, {mem_en, d_done, err, halted});
         end
      end
      do_reset();
      checks++;
      if ({err, halted} !== 2'b00) begin
         failures++;
         $display("FAIL misalign_clear got=%b%b exp=00", err, halted);
      end
   endtask

   task automatic test_rst_mid();
      do_reset();
      if_req = 1'b1; if_addr = 16'h0030; mem_rdata = 16'h7777;
      repeat (5) tick();
      checks++;
      if ({if_done, if_rdata} !== {1'b1, 16'h7777}) begin
         failures++;
         $display("FAIL rstmid_pre got=%b/%h exp=1/7777", if_done, if_rdata);
      end
      if_req = 1'b0;
      tick();
      if_req = 1'b1;
      repeat (3) tick();
      checks++;
      if (mem_en !== 1'b1) begin
         failures++;
         $display("FAIL rstmid_busy got=%b exp=1", mem_en);
      end
      rst = 1'b1; if_req = 1'b0;
      tick();
      checks++;
      if ({mem_en, if_done, stall, halted, if_rdata} !== {4'b0000, 16'h0000}) begin
         failures++;
         $display("FAIL rstmid_idle got=%b%b%b%b/%h exp=0000/0000", mem_en, if_done, stall, halted, if_rdata);
      end
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++;
         if ({mem_en, if_done} !== 2'b00) begin
            failures++;
            $display("FAIL rstmid_quiet k=%0d got=%b%b exp=00", k, mem_en, if_done);
         end
      end
   endtask

   task automatic test_lat1();
      do_reset();
      if_req1 = 1'b1; if_addr1 = 16'h0050; mem_rdata1 = 16'h0F0F;
      tick();
      checks++;
      if ({mem_en1, if_done1, mem_addr1} !== {2'b10, 16'h0050}) begin
         failures++;
         $display("FAIL lat1_busy got=%b%b/%h exp=10/0050", mem_en1, if_done1, mem_addr1);
      end
      tick();
      checks++;
      if ({mem_en1, if_done1, if_rdata1} !== {2'b01, 16'h0F0F}) begin
         failures++;
         $display("FAIL lat1_done got=%b%b/%h exp=01/0f0f", mem_en1, if_done1, if_rdata1);
      end
      if_req1 = 1'b0;
      tick();
      checks++;
      if ({mem_en1, if_done1} !== 2'b00) begin
         failures++;
         $display("FAIL lat1_after got=%b%b exp=00", mem_en1, if_done1);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_back_to_back();
      test_store();
      test_halt();
      test_misalign();
      test_rst_mid();
      test_lat1();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
